// File: rtl/rst_sequencer.sv
// Reset sequencer: holds N_CH reset outputs until PLL lock is stable.
// It then releases each channel at its own cycle offset.
`timescale 1ns/1ps
module rst_sequencer #(
   parameter int                    N_CH        = 4,
   parameter int                    CNT_W       = 20,
   parameter logic [N_CH*CNT_W-1:0] CH_DELAY    = '0,
   parameter int                    LOCK_FILTER = 16,
   parameter logic [N_CH-1:0]       ACTIVE_LOW  = '0
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            trigger_reset,
   input  logic            pll_locked,
   output logic [N_CH-1:0] ch_rst,
   output logic            busy,
   output logic [1:0]      state,
   output logic [7:0]      lock_loss_cnt
);

   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

   function automatic logic [CNT_W-1:0] max_delay();
      logic [CNT_W-1:0] m;
      m = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (CH_DELAY[i*CNT_W +: CNT_W] > m) begin
            m = CH_DELAY[i*CNT_W +: CNT_W];
         end
      end
      return m;
   endfunction

   localparam logic [CNT_W-1:0] MAXD = max_delay();

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } seq_state_e;

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic              lock_meta;
   logic              lock_s;
   logic [FILT_W-1:0] filt_q;
   logic [FILT_W-1:0] filt_d;
   logic [CNT_W-1:0]  seq_q;
   logic [CNT_W-1:0]  seq_d;
   logic [N_CH-1:0]   released_q;
   logic [N_CH-1:0]   released_d;
   logic [7:0]        loss_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= HOLD;
         filt_q        <= '0;
         seq_q         <= '0;
         released_q    <= '0;
         lock_loss_cnt <= '0;
         ch_rst        <= ~ACTIVE_LOW;
      end else begin
         state_q       <= state_d;
         filt_q        <= filt_d;
         seq_q         <= seq_d;
         released_q    <= released_d;
         lock_loss_cnt <= loss_d;
         ch_rst        <= (~released_d) ^ ACTIVE_LOW;
      end
   end

   // ch_rst is registered from released_d so a channel changes on the same edge its flag sets.
   always_comb begin
      state_d    = state_q;
      filt_d     = filt_q;
      seq_d      = seq_q;
      released_d = released_q;
      loss_d     = lock_loss_cnt;

      if (!lock_s || trigger_reset) begin
         filt_d = '0;
      end else if (state_q == HOLD && filt_q != FILT_MAX) begin
         filt_d = filt_q + 1'b1;
      end

      case (state_q)
         HOLD: begin
            seq_d      = '0;
            released_d = '0;
            if (lock_s && !trigger_reset && filt_q == FILT_LAST) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            for (int i = 0; i < N_CH; i++) begin
               if (seq_q >= CH_DELAY[i*CNT_W +: CNT_W]) begin
                  released_d[i] = 1'b1;
               end
            end
            if (seq_q == MAXD) begin
               state_d    = RUN;
               released_d = '1;
            end else begin
               seq_d = seq_q + 1'b1;
            end
         end
         RUN: begin
            released_d = '1;
         end
         default: begin
            state_d    = HOLD;
            seq_d      = '0;
            released_d = '0;
         end
      endcase

      // A trigger outranks a simultaneous lock loss and is not counted as one.
      if (state_q == COUNT || state_q == RUN) begin
         if (trigger_reset) begin
            state_d    = HOLD;
            seq_d      = '0;
            released_d = '0;
         end else if (!lock_s) begin
            state_d    = HOLD;
            seq_d      = '0;
            released_d = '0;
            if (lock_loss_cnt != 8'hFF) begin
               loss_d = lock_loss_cnt + 1'b1;
            end
         end
      end
   end

   assign busy  = (state_q != RUN);
   assign state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer.
// The driver pushes model predictions each cycle, and the monitor compares them after each edge.
`timescale 1ns/1ps
module tb_rst_sequencer;

   localparam int                    N_CH        = 3;
   localparam int                    CNT_W       = 20;
   localparam int                    LOCK_FILTER = 4;
   localparam int                    MAXD        = 100;
   localparam logic [N_CH*CNT_W-1:0] CH_DELAY    = {20'd100, 20'd10, 20'd0};
   localparam logic [N_CH-1:0]       ACTIVE_LOW  = 3'b010;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            trigger_reset = 1'b0;
   logic            pll_locked = 1'b0;
   logic [N_CH-1:0] ch_rst;
   logic            busy;
   logic [1:0]      state;
   logic [7:0]      lock_loss_cnt;

   rst_sequencer #(
      .N_CH        (N_CH),
      .CNT_W       (CNT_W),
      .CH_DELAY    (CH_DELAY),
      .LOCK_FILTER (LOCK_FILTER),
      .ACTIVE_LOW  (ACTIVE_LOW)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .trigger_reset (trigger_reset),
      .pll_locked    (pll_locked),
      .ch_rst        (ch_rst),
      .busy          (busy),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [N_CH-1:0] ch_rst;
      logic [1:0]      state;
      logic            busy;
      logic [7:0]      llc;
   } exp_t;

   exp_t sb_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   bit   active = 1'b0;
   int   delays [N_CH] = '{0, 10, 100};

   // Reference model: tracks only the edge the sequence started on, the qualifying-lock run, and the loss count.
   int   m_now;
   int   m_start;
   int   m_run;
   int   m_losses;
   bit   m_in_seq;
   bit   m_meta;
   bit   m_lock_s;
   bit   prev_rst_n = 1'b0;

   task automatic model_reset();
      m_now    = 0;
      m_start  = 0;
      m_run    = 0;
      m_losses = 0;
      m_in_seq = 1'b0;
      m_meta   = 1'b0;
      m_lock_s = 1'b0;
   endtask

   task automatic model_edge(input bit pll, input bit trig);
      m_now++;
      if (m_in_seq) begin
         if (trig) begin
            m_in_seq = 1'b0;
         end else if (!m_lock_s) begin
            m_in_seq = 1'b0;
            if (m_losses < 255) m_losses++;
         end
         m_run = 0;
      end else if (trig || !m_lock_s) begin
         m_run = 0;
      end else begin
         m_run++;
         if (m_run == LOCK_FILTER) begin
            m_in_seq = 1'b1;
            m_start  = m_now;
         end
      end
      m_lock_s = m_meta;
      m_meta   = pll;
   endtask

   function automatic exp_t reset_outputs();
      exp_t e;
      e.ch_rst = ~ACTIVE_LOW;
      e.state  = 2'd0;
      e.busy   = 1'b1;
      e.llc    = 8'd0;
      return e;
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      int   k;
      e     = reset_outputs();
      e.llc = 8'(m_losses);
      if (m_in_seq) begin
         k       = m_now - m_start;
         e.state = (k > MAXD) ? 2'd2 : 2'd1;
         e.busy  = (k <= MAXD);
         for (int i = 0; i < N_CH; i++) begin
            if (k >= delays[i] + 1) e.ch_rst[i] = ACTIVE_LOW[i];
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input exp_t want);
      tests_run += 4;
      if (ch_rst !== want.ch_rst) begin
         tests_failed++;
         $display("[TB] FAIL %s ch_rst @%0t: got %b want %b", tag, $time, ch_rst, want.ch_rst);
      end
      if (state !== want.state) begin
         tests_failed++;
         $display("[TB] FAIL %s state @%0t: got %0d want %0d", tag, $time, state, want.state);
      end
      if (busy !== want.busy) begin
         tests_failed++;
         $display("[TB] FAIL %s busy @%0t: got %b want %b", tag, $time, busy, want.busy);
      end
      if (lock_loss_cnt !== want.llc) begin
         tests_failed++;
         $display("[TB] FAIL %s lock_loss_cnt @%0t: got %0d want %0d", tag, $time, lock_loss_cnt, want.llc);
      end
   endtask

   // One call per clock cycle: drive the inputs at the falling edge and predict the state after the next rising edge.
   task automatic applyStimulus(input bit rst_n, input bit pll, input bit trig);
      bit falling;
      falling       = prev_rst_n && !rst_n;
      sys_rst_n     = rst_n;
      pll_locked    = pll;
      trigger_reset = trig;
      if (!rst_n) begin
         model_reset();
         if (falling) begin
            #1;
            checkOutput("async_reset", reset_outputs());
         end
         sb_q.push_back(reset_outputs());
      end else begin
         model_edge(pll, trig);
         sb_q.push_back(model_outputs());
      end
      prev_rst_n = rst_n;
      @(negedge sys_clk);
   endtask

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (sb_q.size() > 0) begin
            checkOutput("cycle", sb_q.pop_front());
         end else if (active) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_underflow @%0t: got 0 entries want 1", $time);
         end
      end
   end

   initial begin
      model_reset();
      active = 1'b1;

      $display("[TB] power-on with lock already high");
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (120) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] lock loss in RUN");
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (115) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] lock glitch during HOLD filter");
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (115) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] trigger_reset mid-COUNT");
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (54) applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (115) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] simultaneous trigger and lock loss in RUN");
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (120) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] 260 lock losses");
      for (int n = 0; n < 260; n++) begin
         repeat ($urandom_range(12, 8)) applyStimulus(1'b1, 1'b1, 1'b0);
         repeat ($urandom_range(5, 3)) applyStimulus(1'b1, 1'b0, 1'b0);
      end
      tests_run++;
      if (lock_loss_cnt !== 8'd255) begin
         tests_failed++;
         $display("[TB] FAIL loss_saturation: got %0d want 255", lock_loss_cnt);
      end

      $display("[TB] random lock and trigger traffic");
      for (int n = 0; n < 1500; n++) begin
         applyStimulus(1'b1, $urandom_range(19, 0) != 0, $urandom_range(29, 0) == 0);
      end

      $display("[TB] async reset in RUN");
      repeat (120) applyStimulus(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (state !== 2'd2) begin
         tests_failed++;
         $display("[TB] FAIL run_before_reset: got state %0d want 2", state);
      end
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);

      active = 1'b0;
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
